md_sched: RTL
=============

// Module: md_sched
// PURPOSE
// Multiply/divide sequencer for the 5-stage MIPS pipeline. Sits beside the EX
// stage: accepts mult/multu/div/divu/mthi/mtlo from the ID/EX register, runs a
// fixed-latency busy period, owns the HI/LO registers, and raises a stall
// request so ID holds (and ID/EX is cleared) while an md instruction in ID
// would collide with a running operation.
// PARAMETERS
// MULT_CYCLES  5   busy cycles for mult/multu (>=1)
// DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// clk        in   1   system clock, all state updates on posedge
// reset      in   1   synchronous, active-high
// md_op      in   3   decoded op of instr now in EX (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
// md_a       in   32  EX rs operand (forwarded value)
// md_b       in   32  EX rt operand (forwarded value)
// id_md_use  in   1   instr in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
// start      out  1   combinational: mult/div accepted this cycle
// busy       out  1   registered: operation in progress
// stall_md   out  1   combinational: id_md_use && (start || busy)
// hi         out  32  HI register (read by mfhi in EX)
// lo         out  32  LO register (read by mflo in EX)
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0; start/stall_md follow inputs.
// - FSM IDLE: start = md_op in {MULT,MULTU,DIV,DIVU}. On start edge: latch
//   result into pending regs, cnt<=MULT_CYCLES or DIV_CYCLES, busy<=1, ->BUSY.
// - IDLE MTHI/MTLO: hi<=md_a / lo<=md_a at that edge, busy stays 0, no stall.
// - BUSY: each edge cnt<=cnt-1; at edge where cnt==1: hi/lo<=pending, busy<=0,
//   ->IDLE. busy is high exactly N cycles; new hi/lo visible the cycle busy drops.
// - Arithmetic: MULT {hi,lo}=signed(a)*signed(b) 64-bit; MULTU unsigned.
//   DIV lo=a/b, hi=a%b signed (remainder sign = dividend sign); DIVU unsigned.
//   b==0 for DIV/DIVU: full busy period runs, hi/lo left unchanged.
// - Any md_op while BUSY (cannot occur when stall_md honoured) is ignored:
//   no state change, hi/lo untouched, busy period not restarted.
// - stall_md high in the start cycle too, so a back-to-back md instr in ID waits.
//   mfhi/mflo in ID stalls until busy=0, then reads the updated value.
// - Reset mid-operation: aborts, pending result dropped, hi=lo=0 next cycle.
// - Reset wins over simultaneous start/mthi/mtlo.
// STRUCTURE
// - Shared header md_defs.vh: md_op encodings (NONE=0,MULT,MULTU,DIV,DIVU,
//   MTHI,MTLO), state encodings IDLE/BUSY.
// - One sub-module md_alu: combinational 64-bit mult/div result from op,a,b,
//   plus div-by-zero flag; md_sched holds FSM, counter, pending and HI/LO regs.
// - Top decodes md_op/id_md_use from IR; stall_md ORs into the global stall
//   that freezes PC/IF-ID and drives id_ex clear.
// TESTING
// - MULT a=-3 b=7: start=1 one cycle, busy high 5 cycles, then hi=FFFFFFFF,
//   lo=FFFFFFEB.
// - DIVU a=100 b=7: busy 10 cycles, then lo=14, hi=2; DIV a=-7 b=2 -> lo=-3,hi=-1.
// - MULT then mflo in ID next cycle: stall_md high start cycle + 5 busy cycles,
//   drops when busy=0; mflo reads new lo.
// - MTHI a=0x1234 in IDLE: hi=0x1234 next cycle, busy=0, stall_md=0 throughout.
// - DIV b=0 with hi=5,lo=6: busy 10 cycles, afterward hi=5, lo=6 unchanged.
// - Reset asserted in 3rd busy cycle of DIV: next cycle busy=0, hi=lo=0, IDLE;
//   MULTU 2*3 then accepted normally -> lo=6, hi=0.

Source files
------------

// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared op/state encodings and decode helpers for the md sequencer
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_arith(md_op_e op);
    return is_mult(op) || is_div(op);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - EX-side md request and HI/LO/stall response bundle
interface md_sched_if;
  import md_sched_pkg::*;

  md_op_e      md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        id_md_use;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, md_a, md_b, id_md_use,
    input  start, busy, stall_md, hi, lo
  );

  modport slave (
    input  md_op, md_a, md_b, id_md_use,
    output start, busy, stall_md, hi, lo
  );

endinterface

// File: rtl/md_sched_alu.sv
// rtl/md_sched_alu.sv - combinational 64-bit mult/div result {hi,lo} plus divide-by-zero flag
module md_sched_alu
  import md_sched_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic        [63:0] ua64;
  logic        [63:0] ub64;
  logic        [31:0] b_safe;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;

  // Divisor forced to 1 on zero so the dividers never see x/0; the result is discarded anyway.
  assign b_safe     = (b_i == 32'd0) ? 32'd1 : b_i;
  assign div_zero_o = is_div(op_i) && (b_i == 32'd0);

  always_comb begin
    sa64  = {{32{a_i[31]}}, a_i};
    sb64  = {{32{b_i[31]}}, b_i};
    ua64  = {32'd0, a_i};
    ub64  = {32'd0, b_i};
    sq    = $signed(a_i) / $signed(b_safe);
    sr    = $signed(a_i) % $signed(b_safe);
    uq    = a_i / b_safe;
    ur    = a_i % b_safe;
    res_o = 64'd0;
    case (op_i)
      MD_MULT:  res_o = sa64 * sb64;
      MD_MULTU: res_o = ua64 * ub64;
      MD_DIV:   res_o = {sr, sq};
      MD_DIVU:  res_o = {ur, uq};
      default:  res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - fixed-latency mult/div sequencer owning HI/LO and raising the ID stall
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  md_sched_if.slave  md_if
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [63:0]       pend_q, pend_d;
  logic              start_s;
  logic [63:0]       alu_res;
  logic              alu_div_zero;

  md_sched_alu u_alu (
    .op_i       (md_if.md_op),
    .a_i        (md_if.md_a),
    .b_i        (md_if.md_b),
    .res_o      (alu_res),
    .div_zero_o (alu_div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_arith(md_if.md_op)) begin
          start_s = 1'b1;
          cnt_d   = is_mult(md_if.md_op) ? MULT_LOAD : DIV_LOAD;
          // Divide by zero still burns the full period but writes back the old HI/LO.
          pend_d  = alu_div_zero ? {hi_q, lo_q} : alu_res;
          state_d = ST_BUSY;
        end else if (md_if.md_op == MD_MTHI) begin
          hi_d = md_if.md_a;
        end else if (md_if.md_op == MD_MTLO) begin
          lo_d = md_if.md_a;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign md_if.start    = start_s;
  assign md_if.busy     = (state_q == ST_BUSY);
  assign md_if.stall_md = md_if.id_md_use && (start_s || (state_q == ST_BUSY));
  assign md_if.hi       = hi_q;
  assign md_if.lo       = lo_q;

endmodule
